// File: rtl/combinational_circuit_pkg.sv
// Shared constants and the widened sum compare for combinational_circuit.
// COMBINATIONAL_CIRCUIT_PIPE_EN selects the two-stage build.
package combinational_circuit_pkg;

  localparam int DEF_WIDTH = 16;

`ifdef COMBINATIONAL_CIRCUIT_PIPE_EN
  localparam int LATENCY = 2;
`else
  localparam int LATENCY = 1;
`endif

  // Operands arrive zero-extended to 64 bits; the extra sum bit keeps carry.
  function automatic logic sum_gt(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [63:0] c,
    input logic [63:0] d
  );
    logic [64:0] sab;
    logic [64:0] scd;
    sab = {1'b0, a} + {1'b0, b};
    scd = {1'b0, c} + {1'b0, d};
    return sab > scd;
  endfunction

endpackage

// File: rtl/combinational_circuit_parity.sv
// Balanced XOR-reduction tree; pads to a power of two with zeros.
module combinational_circuit_parity #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] p,
  output logic             par
);

  localparam int LV = $clog2(WIDTH);
  localparam int N  = 1 << LV;

  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    logic [(N>>l)-1:0] v;
    if (l == 0) begin : g_leaf
      assign v = N'(p);
    end else begin : g_node
      for (genvar i = 0; i < (N >> l); i++) begin : g_x
        assign v[i] = g_lvl[l-1].v[2*i] ^ g_lvl[l-1].v[2*i+1];
      end
    end
  end

  assign par = g_lvl[LV].v[0];

endmodule

// File: rtl/combinational_circuit.sv
// Registered parity/sum-compare flag over four operand words.
// COMBINATIONAL_CIRCUIT_PIPE_EN adds a second register stage.
module combinational_circuit
  import combinational_circuit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic             out_signal
);

  logic [WIDTH-1:0] p;
  logic             par;
  logic             gt;

  assign p  = (A & B) | (C ^ D);
  assign gt = sum_gt(64'(A), 64'(B), 64'(C), 64'(D));

  combinational_circuit_parity #(
    .WIDTH(WIDTH)
  ) u_parity (
    .p  (p),
    .par(par)
  );

`ifdef COMBINATIONAL_CIRCUIT_PIPE_EN
  logic par_q;
  logic gt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q      <= 1'b0;
      gt_q       <= 1'b0;
      out_signal <= 1'b0;
    end else begin
      par_q      <= par;
      gt_q       <= gt;
      out_signal <= par_q ^ gt_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_signal <= 1'b0;
    else        out_signal <= par ^ gt;
  end
`endif

endmodule

// File: tb/tb_combinational_circuit.sv
// Directed plus random bench for combinational_circuit.
// Expected values come from an arithmetic model fed through a latency queue.
module tb_combinational_circuit;
  import combinational_circuit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [15:0] C = '0;
  logic [15:0] D = '0;
  logic        out_signal;

  int total = 0;
  int bad = 0;
  logic q[$];

  combinational_circuit #(
    .WIDTH(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .out_signal(out_signal)
  );

  always #5 clk = ~clk;

  function automatic logic model(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [15:0] c,
    input logic [15:0] d
  );
    logic [15:0] pv;
    int sab;
    int scd;
    pv  = (a & b) | (c ^ d);
    sab = int'(a) + int'(b);
    scd = int'(c) + int'(d);
    return ($countones(pv) % 2 == 1) ^ (sab > scd);
  endfunction

  task automatic check(input string tag, input logic exp);
    total++;
    assert (out_signal === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, out_signal, exp);
    end
  endtask

  task automatic reset_q();
    q.delete();
    repeat (LATENCY - 1) q.push_back(1'b0);
  endtask

  // Apply one operand set, clock it, compare the delayed result.
  task automatic step(
    input string       tag,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [15:0] c,
    input logic [15:0] d,
    input logic        f
  );
    logic exp;
    A = a; B = b; C = c; D = d;
    @(posedge clk);
    q.push_back(f);
    exp = q.pop_front();
    #1;
    check(tag, exp);
  endtask

  initial begin
    logic [15:0] ra, rb, rc, rd;
    A = 16'h0003;
    #2;
    check("rst_hold0", 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_hold", 1'b0);
    end
    rst_n = 1'b1;
    reset_q();
    for (int i = 0; i < LATENCY; i++)
      step("rst_release", 16'h0003, 16'h0, 16'h0, 16'h0, 1'b1);

    step("v1", 16'h000F, 16'h00F0, 16'h0F00, 16'hF000, 1'b0);
    step("v2", 16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000, 1'b0);
    step("v3", 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 1'b1);
    step("carry", 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0);
    step("zeros", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    step("allones", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1);
    for (int i = 0; i < LATENCY; i++)
      step("drain", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);

    step("b2b_1", 16'h000F, 16'h00F0, 16'h0F00, 16'hF000, 1'b0);
    step("b2b_2", 16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000, 1'b0);
    step("b2b_3", 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 1'b1);
    step("b2b_4", 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0);
    A = 16'h1234; B = 16'h5678; C = 16'h9ABC; D = 16'hDEF0;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst", 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_mid", 1'b0);
    end
    rst_n = 1'b1;
    reset_q();
    for (int i = 0; i < LATENCY; i++)
      step("post_rst", 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 1'b1);

    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 16'($urandom);
      rd = 16'($urandom);
      if (i % 16 == 0) begin
        ra = 16'hFFFF;
        rb = 16'($urandom_range(1, 3));
      end
      step("rand", ra, rb, rc, rd, model(ra, rb, rc, rd));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
